// File: rtl/hex_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display with anti-ghosting blanking
// and frame-synchronous value updates. Define HEXSCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [3:0]            nibble,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [4*DIGITS-1:0] shadow_value_reg;
  logic [DIGITS-1:0]   shadow_dp_reg;
  logic                pending_reg;
  logic [4*DIGITS-1:0] active_value_reg;
  logic [DIGITS-1:0]   active_dp_reg;
  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic                run_reg;

  logic                boundary;
  logic                transfer;
  logic [4*DIGITS-1:0] active_value_next;
  logic [DIGITS-1:0]   active_dp_next;
  logic [CW-1:0]       cnt_next;
  logic [IW-1:0]       idx_next;
  logic [0:0]          slot_state;
  logic [3:0]          nib_arr [DIGITS];
  logic [DIGITS-1:0]   blank_digit;
  logic [DIGITS-1:0]   sel_next;

  // Outputs are registered from the next-state values so they always match cnt/idx.
  always_comb begin
    boundary          = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
    // run_reg low means the previous edge was disabled: this edge restarts the scan.
    transfer          = enable && pending_reg && (boundary || !run_reg);
    active_value_next = transfer ? shadow_value_reg : active_value_reg;
    active_dp_next    = transfer ? shadow_dp_reg : active_dp_reg;
    cnt_next          = '0;
    idx_next          = '0;
    if (enable) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
      end
    end
    slot_state = (enable && (cnt_next >= CNT_SHOW)) ? ST_SHOW : ST_BLANK;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_arr[gi] = active_value_next[4*gi +: 4];
  end

`ifdef HEXSCAN_LZB_EN
  logic zero_run;

  // Walk from the most significant digit down, tracking whether everything above is zero.
  always_comb begin
    zero_run    = 1'b1;
    blank_digit = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (nib_arr[i] == 4'h0);
      if ((i != 0) && !active_dp_next[i] && zero_run) begin
        blank_digit[i] = 1'b1;
      end
    end
  end
`else
  assign blank_digit = '0;
`endif

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
    assign sel_next[gi] = !((slot_state == ST_SHOW) && (idx_next == IW'(gi)) && !blank_digit[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      pending_reg      <= 1'b0;
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      run_reg          <= 1'b0;
      nibble           <= 4'h0;
      dp_n             <= 1'b1;
      digit_sel        <= '1;
      frame_tick       <= 1'b0;
    end else begin
      // A load coinciding with a transfer keeps pending set: the new value waits a frame.
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp_in;
        pending_reg      <= 1'b1;
      end else if (transfer) begin
        pending_reg      <= 1'b0;
      end
      active_value_reg <= active_value_next;
      active_dp_reg    <= active_dp_next;
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      run_reg          <= enable;
      nibble           <= nib_arr[idx_next];
      dp_n             <= ~active_dp_next[idx_next];
      digit_sel        <= sel_next;
      frame_tick       <= (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Self-checking bench for hex_scan_mux (DIGITS=4, PRESCALE=8, BLANK=2): frame tables,
// hand-written corner sequences and randomized traffic against a position-based model.
module tb_hex_scan_mux;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  nibble;
  logic        dp_n;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  hex_scan_mux #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .nibble(nibble), .dp_n(dp_n), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_pos counts enabled edges since the scan last (re)started.
  logic [15:0] m_sh_val, m_act_val;
  logic [3:0]  m_sh_dp, m_act_dp;
  bit          m_pending, m_run;
  int          m_pos;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [15:0] nibs;
    logic [3:0]  dpn;
    logic [15:0] sels;
  } frame_vec_t;

  frame_vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh_val = '0; m_act_val = '0; m_sh_dp = '0; m_act_dp = '0;
    m_pending = 0; m_run = 0; m_pos = 0;
  endtask

  task automatic model_update();
    if (reset) return;
    if (enable) begin
      if (m_pending && (!m_run || (m_pos % FRAME == FRAME - 1))) begin
        m_act_val = m_sh_val;
        m_act_dp  = m_sh_dp;
        m_pending = 0;
      end
      m_pos++;
    end else begin
      m_pos = 0;
    end
    m_run = enable;
    if (load) begin
      m_sh_val  = value;
      m_sh_dp   = dp_in;
      m_pending = 1;
    end
  endtask

  function automatic logic [3:0] exp_sel(input int c, input int i);
    logic [3:0] r;
`ifdef HEXSCAN_LZB_EN
    bit allz;
`endif
    r = 4'hF;
    if (m_run && c >= B) begin
      r[i] = 1'b0;
`ifdef HEXSCAN_LZB_EN
      allz = 1;
      for (int k = i; k < D; k++) if (m_act_val[4*k +: 4] != 4'h0) allz = 0;
      if (i != 0 && !m_act_dp[i] && allz) r = 4'hF;
`endif
    end
    return r;
  endfunction

  task automatic check_model();
    int c, i;
    logic edp, etick;
    c = m_pos % P;
    i = (m_pos / P) % D;
    edp = ~m_act_dp[i];
    etick = m_run && (m_pos % FRAME == FRAME - 1);
    check("model_nibble", nibble, m_act_val[4*i +: 4]);
    check("model_dp_n", dp_n, edp);
    check("model_digit_sel", digit_sel, exp_sel(c, i));
    check("model_frame_tick", frame_tick, etick);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (frame_tick !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_tick got %0b expected 1 within 100 cycles", tag, frame_tick);
    end
  endtask

  task automatic check_frame(input frame_vec_t v, input string tag);
    int s, c;
    logic [15:0] nibs, sels;
    logic [3:0] dpn, esel;
    logic etick;
    nibs = v.nibs; sels = v.sels; dpn = v.dpn;
    wait_tick(tag);
    for (int k = 0; k < FRAME; k++) begin
      step();
      s = k / P;
      c = k % P;
      esel = (c < B) ? 4'hF : sels[4*s +: 4];
      etick = (k == FRAME - 1);
      check({tag, "_nibble"}, nibble, nibs[4*s +: 4]);
      check({tag, "_dp_n"}, dp_n, dpn[s]);
      check({tag, "_sel"}, digit_sel, esel);
      check({tag, "_tick"}, frame_tick, etick);
    end
  endtask

  initial begin
    vecs[0] = '{value: 16'h1234, dp: 4'b0100, nibs: 16'h1234, dpn: 4'b1011, sels: 16'h7BDE};
`ifdef HEXSCAN_LZB_EN
    vecs[1] = '{value: 16'h0040, dp: 4'b0000, nibs: 16'h0040, dpn: 4'b1111, sels: 16'hFFDE};
    vecs[2] = '{value: 16'h0000, dp: 4'b1000, nibs: 16'h0000, dpn: 4'b0111, sels: 16'h7FFE};
`else
    vecs[1] = '{value: 16'h0040, dp: 4'b0000, nibs: 16'h0040, dpn: 4'b1111, sels: 16'h7BDE};
    vecs[2] = '{value: 16'h0000, dp: 4'b1000, nibs: 16'h0000, dpn: 4'b0111, sels: 16'h7BDE};
`endif
    model_reset();

    // Reset with enable high
    repeat (2) @(negedge clk);
    check("rst_nibble", nibble, 4'h0);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_sel", digit_sel, 4'hF);
    check("rst_tick", frame_tick, 1'b0);
    reset = 1'b0;
    for (int k = 1; k < P; k++) begin
      step();
      check("idle_sel", digit_sel, (k >= B) ? 4'hE : 4'hF);
    end

    // Frame tables: load, then the following frame shows the new value
    for (int v = 0; v < 3; v++) begin
      value = vecs[v].value; dp_in = vecs[v].dp; load = 1'b1;
      step();
      load = 1'b0;
      check_frame(vecs[v], $sformatf("frame%0d", v));
    end

    // No tearing: load during slot 1 is not seen until the next frame
    value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    run(FRAME);
    check("tear_start", nibble, 4'h4);
    run(10);
    value = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    run(9);
    check("tear_slot2", nibble, 4'h2);
    run(8);
    check("tear_slot3", nibble, 4'h1);
    run(4);
    check("tear_new", nibble, 4'hD);

    // Coincident load at frame_tick
    run(5);
    value = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;
    run(25);
    check("coin_tick", frame_tick, 1'b1);
    value = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    check("coin_old", nibble, 4'h9);
    run(FRAME);
    check("coin_new", nibble, 4'h5);

    // Enable drop at cnt=5 idx=2, load while disabled, re-enable
    run(21);
    check("en_before", digit_sel, 4'hB);
    enable = 1'b0;
    step();
    check("en_off_sel", digit_sel, 4'hF);
    check("en_off_tick", frame_tick, 1'b0);
    value = 16'h7777; load = 1'b1;
    step();
    load = 1'b0;
    run(2);
    enable = 1'b1;
    step();
    check("en_on_nibble", nibble, 4'h7);
    check("en_on_sel", digit_sel, 4'hF);
    step();
    check("en_on_show", digit_sel, 4'hE);

    // Asynchronous reset mid-slot
    run(13);
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_nibble", nibble, 4'h0);
    check("arst_dp_n", dp_n, 1'b1);
    check("arst_sel", digit_sel, 4'hF);
    check("arst_tick", frame_tick, 1'b0);
    run(2);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      load   = ($urandom_range(0, 9) == 0);
      value  = 16'($urandom);
      dp_in  = 4'($urandom);
      enable = ($urandom_range(0, 79) != 0);
      step();
    end
    load = 1'b0;
    enable = 1'b1;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
